// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: serialises branch-predictor writes from two execute lanes and BTB clear sweeps onto one update port.
//
// Ports:
//   clock_i, reset_n_i                 clock, asynchronous active-low reset
//   res{0,1}_valid_i/pc_i/tgt_i        resolved control transfer from execute lane 0/1
//   res{0,1}_taken_i/cond_i            taken outcome, conditional-branch flag
//   sweep_req_i                        pulse requesting a full BTB clear sweep
//   update_pc_o, update_tgt_o          registered predictor update address / target
//   last_br_o                          registered taken outcome for the PHT
//   update_pht_o, update_btb_o         registered PHT / BTB write enables
//   stall_o                            hold request: not in RUN or fewer than two free slots
//   busy_o                             sweeping or draining
//   overflow_o                         one-cycle pulse when an eligible result was dropped
//   count_o                            FIFO occupancy
module bp_update_scheduler #(
    parameter int ABITS = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       res0_valid_i,
    input  logic [31:0]                res0_pc_i,
    input  logic [31:0]                res0_tgt_i,
    input  logic                       res0_taken_i,
    input  logic                       res0_cond_i,
    input  logic                       res1_valid_i,
    input  logic [31:0]                res1_pc_i,
    input  logic [31:0]                res1_tgt_i,
    input  logic                       res1_taken_i,
    input  logic                       res1_cond_i,
    input  logic                       sweep_req_i,
    output logic [31:0]                update_pc_o,
    output logic [31:0]                update_tgt_o,
    output logic                       last_br_o,
    output logic                       update_pht_o,
    output logic                       update_btb_o,
    output logic                       stall_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {SWEEP, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        cond;
    } entry_t;

    state_t           state, state_d;
    logic [ABITS-1:0] idx, idx_d;
    entry_t           mem [DEPTH];
    entry_t           e0, e1, head;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    free;
    logic             elig0, elig1, acc0, acc1, pop, drop;
    logic [31:0]      pc_d, tgt_d;
    logic             br_d, pht_d, btb_d;

    assign e0    = {res0_pc_i, res0_tgt_i, res0_taken_i, res0_cond_i};
    assign e1    = {res1_pc_i, res1_tgt_i, res1_taken_i, res1_cond_i};
    assign head  = mem[rd_ptr];
    // Not-taken unconditional results carry no predictor information.
    assign elig0 = res0_valid_i & (res0_cond_i | res0_taken_i);
    assign elig1 = res1_valid_i & (res1_cond_i | res1_taken_i);
    // The FIFO drains in RUN and DRAIN only; the sweep owns the port in SWEEP.
    assign pop   = (state != SWEEP) && (count_o != '0);
    // Free slots counted after this cycle's pop so a full FIFO can still accept one push.
    assign free  = CW'(DEPTH) - count_o + CW'(pop);
    assign acc0  = elig0 && (free != '0);
    assign acc1  = elig1 && (free > CW'(acc0));
    assign drop  = (elig0 & ~acc0) | (elig1 & ~acc1);

    assign busy_o  = (state != RUN);
    assign stall_o = (state != RUN) || ((DEPTH - int'(count_o)) < 2);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= SWEEP;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // DRAIN leaves once the entry being popped is the last one (or nothing is left).
    always_comb begin
        state_d = state;
        if (state == SWEEP && idx == '1)
            state_d = RUN;
        else if (state == RUN && sweep_req_i)
            state_d = DRAIN;
        else if (state == DRAIN && count_o <= CW'(1))
            state_d = SWEEP;
        idx_d = (state == SWEEP) ? idx + ABITS'(1) : '0;
    end

    always_comb begin
        pc_d  = (state == SWEEP) ? 32'({idx, 2'b00}) : pop ? head.pc : update_pc_o;
        tgt_d = (state == SWEEP) ? 32'd0 : pop ? head.tgt : update_tgt_o;
        br_d  = (state == SWEEP) ? 1'b0 : pop ? head.taken : last_br_o;
        pht_d = pop & head.cond;
        btb_d = (state == SWEEP) | (pop & head.taken);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            update_pc_o  <= '0;
            update_tgt_o <= '0;
            last_br_o    <= 1'b0;
            update_pht_o <= 1'b0;
            update_btb_o <= 1'b0;
            overflow_o   <= 1'b0;
            count_o      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            update_pc_o  <= pc_d;
            update_tgt_o <= tgt_d;
            last_br_o    <= br_d;
            update_pht_o <= pht_d;
            update_btb_o <= btb_d;
            overflow_o   <= drop;
            count_o      <= count_o + CW'(acc0) + CW'(acc1) - CW'(pop);
            rd_ptr       <= rd_ptr + PW'(pop);
            wr_ptr       <= wr_ptr + PW'(acc0) + PW'(acc1);
        end
    end

    // Lane 1 lands behind lane 0 when both are accepted in the same cycle.
    always_ff @(posedge clock_i) begin
        if (acc0)
            mem[wr_ptr] <= e0;
        if (acc1)
            mem[wr_ptr + PW'(acc0)] <= e1;
    end
endmodule
